traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

- Passive checker that observes the three lamp lines driven by `traffic_light_control` (`output_x/y/z`) and decodes them into a phase code.
- Enforces the legal phase sequence and per-phase dwell limits, and counts completed light cycles.
- Sits alongside the controller in the Traffic_Light_Control design as the consumer of its lamp outputs, usable in the system and as a bench scoreboard.

## Interface

Parameters:
- `MIN_DWELL`, 5: minimum legal cycles in any phase. Must be ≥1.
- `MAX_DWELL`, 64: cycles after which a phase that has not changed is flagged. Must be > `MIN_DWELL`.
- `CNT_W`, 8: width of the completed-cycle counter.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rstb` input 1: reset, synchronous, active-low.
- `lamp_x` input 1: red lamp, from controller `output_x`.
- `lamp_y` input 1: amber lamp, from controller `output_y`.
- `lamp_z` input 1: green lamp, from controller `output_z`.
- `err_clr` input 1: clears the sticky `fault` flag.
- `phase` output 2: decoded phase. 00 UNKNOWN, 01 RED, 10 AMBER, 11 GREEN.
- `err_code` output 1: one-cycle pulse on entry into an illegal lamp code.
- `err_seq` output 1: one-cycle pulse on an illegal phase transition.
- `err_short` output 1: one-cycle pulse when a phase ends before `MIN_DWELL`.
- `err_timeout` output 1: one-cycle pulse when a phase reaches `MAX_DWELL`.
- `fault` output 1: sticky OR of all error pulses.
- `cycle_cnt` output `CNT_W`: number of completed RED→GREEN transitions; wraps.

## Operation

- **Input sampling.** Lamps are registered into `lamp_q` every cycle; all decoding uses `lamp_q`.
- **Lamp decode of {x,y,z}.** 100 is RED, 010 is AMBER, 001 is GREEN. Any other value (000, or more than one lamp lit) is ILLEGAL.
- **State register.** Holds `phase` (UNKNOWN/RED/AMBER/GREEN) and dwell counter `dwell` of width `$clog2(MAX_DWELL+1)`.
- **Legal code equal to current phase:**
  - `dwell` increments, saturating at `MAX_DWELL`.
  - `err_timeout` pulses on the cycle `dwell` transitions from `MAX_DWELL-1` to `MAX_DWELL`. It does not pulse again while saturated.
- **Legal code different from current phase:**
  - `phase` takes the new value and `dwell` is set to 1.
  - If the old phase was UNKNOWN, there is no further check.
  - Otherwise:
    - Legal transitions are GREEN→AMBER, AMBER→RED and RED→GREEN. Any other transition pulses `err_seq`; the new phase is still adopted.
    - If old `dwell` < `MIN_DWELL`, `err_short` pulses.
    - A legal RED→GREEN transition increments `cycle_cnt` (modulo 2^`CNT_W`).
- **ILLEGAL code:**
  - On entry, `phase` becomes UNKNOWN, `dwell` becomes 0 and `err_code` pulses once. There is no pulse while the code stays illegal.
  - The next legal code re-enters from UNKNOWN with no `err_seq` or `err_short` check.
- **Sticky fault.**
  - `fault` sets on any error pulse.
  - `err_clr` clears it.
  - If `err_clr` and a new error pulse occur in the same cycle, `fault` stays 1.
- **Simultaneous errors.** `err_seq` and `err_short` can pulse in the same cycle.

## Timing

- **Reset (`rstb`=0 at a rising edge).**
  - `lamp_q` becomes 000.
  - `phase` becomes UNKNOWN, `dwell` and `cycle_cnt` become 0.
  - All error outputs and `fault` become 0.
  - Reset overrides `err_clr` and any lamp activity.
  - Reset mid-phase loses all history. No error is generated by the re-entry after reset.
  - The 000 code captured in `lamp_q` during reset does not raise `err_code` until `rstb`=1.
- **Latency.**
  - A lamp change sampled at edge N appears in `lamp_q` after edge N.
  - `phase`, `dwell`, the error pulses and `cycle_cnt` update at edge N+1. Input-to-output latency is 2 cycles.
- **Registered outputs.** All outputs are registered; there are no combinational paths from input to output.
- **Pulse width.** Error pulses are exactly one cycle wide.

## Structure

- **Package `traffic_light_pkg`** contains:
  - the `phase_t` enum (UNKNOWN=2'b00, RED=2'b01, AMBER=2'b10, GREEN=2'b11);
  - lamp code constants `LAMP_RED=3'b100`, `LAMP_AMBER=3'b010`, `LAMP_GREEN=3'b001`;
  - function `lamp_decode(logic [2:0]) -> phase_t`, which returns UNKNOWN for ILLEGAL codes and is used together with a separate `is_legal` flag;
  - function `legal_next(phase_t from, phase_t to)`.
- **Sub-module `tl_dwell_counter`** implements the saturating counter.
  - Inputs: `clk`, `rstb`, `load1`, `clear`, `inc`.
  - Outputs: `count` and `hit_max` (one-cycle pulse on reaching the limit).
  - Parameterised on `MAX_DWELL`.
- **Top level** contains the decode, the phase/transition checks, `cycle_cnt` and `fault`.

## Test plan

1. **Reset.** Hold `rstb`=0 for 3 cycles with lamps=001.
   - `phase`=00, `cycle_cnt`=0, `fault`=0 throughout.
   - 2 cycles after release, `phase`=11 and there are no error pulses.
2. **Legal cycle.** Release reset, then drive GREEN 8, AMBER 6, RED 10, GREEN 8 cycles, repeated 3 times.
   - `phase` follows with 2-cycle lag.
   - `cycle_cnt` = 1, 2, 3 at each RED→GREEN transition.
   - No error pulses.
3. **Short dwell and bad sequence.** GREEN 8 cycles, then RED 3 cycles, then GREEN.
   - On GREEN→RED: `err_seq` pulses 1 cycle and `fault`=1.
   - On RED→GREEN after 3 cycles: `err_short` pulses and `cycle_cnt` increments.
4. **Illegal code.** From AMBER, drive 110 for 4 cycles, then RED.
   - Exactly one `err_code` pulse.
   - `phase`=00 during the illegal code, then 01.
   - No `err_seq` or `err_short` on the RED entry.
5. **Timeout.** Hold RED for 100 cycles.
   - Single `err_timeout` pulse 2+63 cycles after RED was applied.
   - `dwell` saturates and there are no further pulses.
6. **Clear versus new error.**
   - With `fault`=1, pulse `err_clr`: `fault`=0 the next cycle.
   - Assert `err_clr` in the same cycle as an `err_seq` pulse: `fault` remains 1.
   - Additionally, with `CNT_W`=2, run 5 legal cycles: `cycle_cnt` wraps to 1.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types and helpers for the traffic light monitor.
//   phase_t     : decoded lamp phase (UNKNOWN/RED/AMBER/GREEN)
//   LAMP_*      : one-hot lamp codes in {x,y,z} order
//   is_legal    : true when exactly one lamp of the three is lit
//   lamp_decode : lamp code to phase, UNKNOWN for illegal codes
//   legal_next  : true for the permitted phase steps G->A, A->R, R->G
package traffic_light_pkg;

    typedef enum logic [1:0] {
        UNKNOWN = 2'b00,
        RED     = 2'b01,
        AMBER   = 2'b10,
        GREEN   = 2'b11
    } phase_t;

    localparam logic [2:0] LAMP_RED   = 3'b100;
    localparam logic [2:0] LAMP_AMBER = 3'b010;
    localparam logic [2:0] LAMP_GREEN = 3'b001;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == LAMP_RED) || (code == LAMP_AMBER) || (code == LAMP_GREEN);
    endfunction

    function automatic phase_t lamp_decode(input logic [2:0] code);
        phase_t ph;
        case (code)
            LAMP_RED:   ph = RED;
            LAMP_AMBER: ph = AMBER;
            LAMP_GREEN: ph = GREEN;
            default:    ph = UNKNOWN;
        endcase
        return ph;
    endfunction

    function automatic logic legal_next(input phase_t from, input phase_t to);
        return ((from == GREEN) && (to == AMBER)) ||
               ((from == AMBER) && (to == RED))   ||
               ((from == RED)   && (to == GREEN));
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp observation bus between a traffic light controller (or bench) and
// the monitor.
//   master : drives lamp_x/y/z and err_clr, observes the monitor results
//   slave  : the monitor; samples lamps/err_clr, drives phase, error
//            pulses, fault and cycle_cnt
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    import traffic_light_pkg::*;

    logic             lamp_x;
    logic             lamp_y;
    logic             lamp_z;
    logic             err_clr;
    phase_t           phase;
    logic             err_code;
    logic             err_seq;
    logic             err_short;
    logic             err_timeout;
    logic             fault;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output lamp_x, lamp_y, lamp_z, err_clr,
        input  phase, err_code, err_seq, err_short, err_timeout, fault, cycle_cnt
    );

    modport slave (
        input  lamp_x, lamp_y, lamp_z, err_clr,
        output phase, err_code, err_seq, err_short, err_timeout, fault, cycle_cnt
    );

endinterface

// File: rtl/tl_dwell_counter.sv
// Saturating dwell counter for the current lamp phase.
//   clk, rstb : clock, synchronous active-low reset
//   clear     : force count to 0 (highest priority)
//   load1     : start a new phase, count = 1
//   inc       : add one, saturating at MAX_DWELL
//   count     : current dwell
//   hit_max   : registered one-cycle pulse on the MAX_DWELL-1 -> MAX_DWELL step
module tl_dwell_counter #(
    parameter int MAX_DWELL = 64,
    localparam int W = $clog2(MAX_DWELL + 1)
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         load1,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         hit_max
);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            count   <= '0;
            hit_max <= 1'b0;
        end else begin
            hit_max <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (load1) begin
                count <= W'(1);
            end else if (inc && (count != W'(MAX_DWELL))) begin
                count   <= count + W'(1);
                hit_max <= (count == W'(MAX_DWELL - 1));
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the controller lamp lines. Decodes the registered
// lamp code into a phase, checks phase order and dwell limits, counts
// completed RED->GREEN cycles and keeps a sticky fault flag.
//   clk, rstb : clock, synchronous active-low reset
//   mon       : slave side of the lamp observation bus (lamps and err_clr
//               in; phase, err_* pulses, fault, cycle_cnt out)
//
// phase_q | meaning
// UNKNOWN | after reset or while the lamp code is illegal
// RED     | red lamp alone
// AMBER   | amber lamp alone
// GREEN   | green lamp alone
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int MIN_DWELL = 5,
    parameter int MAX_DWELL = 64,
    parameter int CNT_W     = 8
) (
    input logic                     clk,
    input logic                     rstb,
    traffic_light_monitor_if.slave  mon
);

    localparam int DW = $clog2(MAX_DWELL + 1);

    logic [2:0]       lamp_q;
    phase_t           phase_q;
    logic             in_illegal_q;
    logic             err_code_q;
    logic             err_seq_q;
    logic             err_short_q;
    logic             fault_q;
    logic [CNT_W-1:0] cycle_cnt_q;

    logic [DW-1:0]    dwell;
    logic             hit_max;

    logic             code_ok;
    phase_t           code_ph;
    logic             same_ph;
    logic             new_ph;
    logic             checked;
    logic             code_nxt;
    logic             seq_nxt;
    logic             short_nxt;
    logic             timeout_nxt;
    logic             wrap_nxt;

    assign code_ok = is_legal(lamp_q);
    assign code_ph = lamp_decode(lamp_q);
    assign same_ph = code_ok && (code_ph == phase_q);
    assign new_ph  = code_ok && (code_ph != phase_q);

    // Re-entry from UNKNOWN (reset or illegal code) carries no history to check.
    assign checked     = new_ph && (phase_q != UNKNOWN);
    assign code_nxt    = !code_ok && !in_illegal_q;
    assign seq_nxt     = checked && !legal_next(phase_q, code_ph);
    assign short_nxt   = checked && (dwell < DW'(MIN_DWELL));
    assign wrap_nxt    = checked && (phase_q == RED) && (code_ph == GREEN);
    // Mirrors the counter's hit_max condition so fault sets on the same edge.
    assign timeout_nxt = same_ph && (dwell == DW'(MAX_DWELL - 1));

    tl_dwell_counter #(
        .MAX_DWELL (MAX_DWELL)
    ) u_dwell (
        .clk     (clk),
        .rstb    (rstb),
        .load1   (new_ph),
        .clear   (!code_ok),
        .inc     (same_ph),
        .count   (dwell),
        .hit_max (hit_max)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            lamp_q       <= 3'b000;
            phase_q      <= UNKNOWN;
            // Treat reset as already inside an illegal code so the 000 held in
            // lamp_q during reset does not report an err_code after release.
            in_illegal_q <= 1'b1;
            err_code_q   <= 1'b0;
            err_seq_q    <= 1'b0;
            err_short_q  <= 1'b0;
            fault_q      <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            lamp_q       <= {mon.lamp_x, mon.lamp_y, mon.lamp_z};
            in_illegal_q <= !code_ok;
            if (new_ph) begin
                phase_q <= code_ph;
            end else if (!code_ok) begin
                phase_q <= UNKNOWN;
            end
            err_code_q  <= code_nxt;
            err_seq_q   <= seq_nxt;
            err_short_q <= short_nxt;
            if (wrap_nxt) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            // A new error wins over a simultaneous clear.
            fault_q <= (fault_q && !mon.err_clr) ||
                       code_nxt || seq_nxt || short_nxt || timeout_nxt;
        end
    end

    assign mon.phase       = phase_q;
    assign mon.err_code    = err_code_q;
    assign mon.err_seq     = err_seq_q;
    assign mon.err_short   = err_short_q;
    assign mon.err_timeout = hit_max;
    assign mon.fault       = fault_q;
    assign mon.cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
`timescale 1ns/1ps
module tb_traffic_light_monitor;
    import traffic_light_pkg::*;

    localparam int MIN_D = 5;
    localparam int MAX_D = 64;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] A = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] lamps = 3'b001;

    always #5 clk = ~clk;

    traffic_light_monitor_if #(.CNT_W(8)) bus_a ();
    traffic_light_monitor_if #(.CNT_W(2)) bus_b ();

    assign bus_a.lamp_x  = lamps[2];
    assign bus_a.lamp_y  = lamps[1];
    assign bus_a.lamp_z  = lamps[0];
    assign bus_a.err_clr = err_clr;
    assign bus_b.lamp_x  = lamps[2];
    assign bus_b.lamp_y  = lamps[1];
    assign bus_b.lamp_z  = lamps[0];
    assign bus_b.err_clr = err_clr;

    traffic_light_monitor #(.MIN_DWELL(MIN_D), .MAX_DWELL(MAX_D), .CNT_W(8)) dut_a (
        .clk (clk), .rstb (rstb), .mon (bus_a)
    );
    traffic_light_monitor #(.MIN_DWELL(MIN_D), .MAX_DWELL(MAX_D), .CNT_W(2)) dut_b (
        .clk (clk), .rstb (rstb), .mon (bus_b)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: history of lamp codes as the monitor sees them,
    // expected outputs derived from run lengths of identical codes.
    int hist[$];
    int pipe;
    bit mvalid = 0;
    int m_phase, m_code, m_seq, m_short, m_to, m_fault, m_total;
    int cur, prv;
    bit prev_ok, cur_ok;

    function automatic bit f_legal(input int c);
        return (c == 4) || (c == 2) || (c == 1);
    endfunction

    function automatic int f_phase(input int c);
        case (c)
            4: return 1;
            2: return 2;
            1: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic bit f_step_ok(input int a, input int b);
        return (a == 1 && b == 2) || (a == 2 && b == 4) || (a == 4 && b == 1);
    endfunction

    function automatic int tail_run();
        int n = 0;
        int last;
        if (hist.size() == 0) return 0;
        last = hist[hist.size() - 1];
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != last) break;
            n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rstb) begin
            hist.delete();
            pipe = 0;
            m_phase = 0; m_code = 0; m_seq = 0; m_short = 0; m_to = 0;
            m_fault = 0; m_total = 0;
            mvalid = 1;
        end else begin
            cur = pipe;
            prev_ok = (hist.size() > 0) && f_legal(hist[hist.size() - 1]);
            prv = (hist.size() > 0) ? hist[hist.size() - 1] : 0;
            cur_ok = f_legal(cur);
            m_code = (!cur_ok && prev_ok) ? 1 : 0;
            m_seq = 0; m_short = 0;
            if (cur_ok && prev_ok && cur != prv) begin
                m_seq = f_step_ok(prv, cur) ? 0 : 1;
                m_short = (tail_run() < MIN_D) ? 1 : 0;
                if (prv == 4 && cur == 1) m_total++;
            end
            hist.push_back(cur);
            if (hist.size() > 200) void'(hist.pop_front());
            m_to = (cur_ok && tail_run() == MAX_D) ? 1 : 0;
            m_fault = ((m_fault != 0 && !err_clr) || m_code != 0 || m_seq != 0 ||
                       m_short != 0 || m_to != 0) ? 1 : 0;
            m_phase = f_phase(cur);
            pipe = int'(lamps);
        end
    end

    int n_code = 0, n_seq = 0, n_short = 0, n_to = 0;

    always @(posedge clk) begin
        #1;
        if (mvalid) begin
            check("phase_a",   int'(bus_a.phase),       m_phase);
            check("code_a",    int'(bus_a.err_code),    m_code);
            check("seq_a",     int'(bus_a.err_seq),     m_seq);
            check("short_a",   int'(bus_a.err_short),   m_short);
            check("timeout_a", int'(bus_a.err_timeout), m_to);
            check("fault_a",   int'(bus_a.fault),       m_fault);
            check("cnt_a",     int'(bus_a.cycle_cnt),   m_total % 256);
            check("phase_b",   int'(bus_b.phase),       m_phase);
            check("errs_b",    int'({bus_b.err_code, bus_b.err_seq, bus_b.err_short, bus_b.err_timeout}),
                               m_code*8 + m_seq*4 + m_short*2 + m_to);
            check("fault_b",   int'(bus_b.fault),       m_fault);
            check("cnt_b",     int'(bus_b.cycle_cnt),   m_total % 4);
            if (bus_a.err_code)    n_code++;
            if (bus_a.err_seq)     n_seq++;
            if (bus_a.err_short)   n_short++;
            if (bus_a.err_timeout) n_to++;
        end
    end

    task automatic hold(input logic [2:0] c, input int n);
        lamps = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic legal_round();
        hold(G, 8); hold(A, 6); hold(R, 10);
    endtask

    initial begin
        int b_code, b_seq, b_short, b_to, at_k, r, dur;
        int ill_codes[5];
        logic [2:0] nxt;
        ill_codes[0] = 0; ill_codes[1] = 3; ill_codes[2] = 5;
        ill_codes[3] = 6; ill_codes[4] = 7;

        // Reset with GREEN lit
        rstb = 1'b0; lamps = G; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_phase_green_after_release", int'(bus_a.phase), 3);

        // Legal cycles
        for (int i = 0; i < 3; i++) begin
            hold(G, 8); hold(A, 6); hold(R, 10); hold(G, 8);
        end
        repeat (3) @(negedge clk);
        check("t2_cycle_cnt", int'(bus_a.cycle_cnt), 3);
        check("t2_no_errors", n_code + n_seq + n_short + n_to, 0);
        check("t2_fault", int'(bus_a.fault), 0);

        // Bad sequence then short dwell
        hold(G, 8);
        b_seq = n_seq; b_short = n_short;
        hold(R, 3); hold(G, 8);
        check("t3_seq_pulses", n_seq - b_seq, 1);
        check("t3_short_pulses", n_short - b_short, 1);
        check("t3_fault", int'(bus_a.fault), 1);
        check("t3_cycle_cnt", int'(bus_a.cycle_cnt), 4);

        // Illegal code from AMBER
        hold(A, 6);
        b_code = n_code; b_seq = n_seq; b_short = n_short;
        hold(3'b110, 2);
        check("t4_phase_unknown", int'(bus_a.phase), 0);
        hold(3'b110, 2);
        hold(R, 8);
        check("t4_code_pulses", n_code - b_code, 1);
        check("t4_no_seq_short", (n_seq - b_seq) + (n_short - b_short), 0);
        check("t4_phase_red", int'(bus_a.phase), 1);

        // Timeout
        hold(G, 8); hold(A, 6);
        b_to = n_to; at_k = 0;
        lamps = R;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus_a.err_timeout && at_k == 0) at_k = i;
        end
        check("t5_timeout_cycle", at_k, 65);
        check("t5_timeout_pulses", n_to - b_to, 1);

        // Clear versus new error
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        check("t6_fault_cleared", int'(bus_a.fault), 0);
        lamps = A; @(negedge clk);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        check("t6_seq_with_clr", int'(bus_a.err_seq), 1);
        check("t6_fault_kept", int'(bus_a.fault), 1);
        hold(A, 8);

        // Counter wrap on the 2-bit instance
        rstb = 1'b0; lamps = G;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 5; i++) legal_round();
        hold(G, 8);
        check("t7_cnt2_wrap", int'(bus_b.cycle_cnt), 1);
        check("t7_cnt8", int'(bus_a.cycle_cnt), 5);

        // Randomized traffic
        nxt = G;
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rstb = 1'b0;
                repeat (2) @(negedge clk);
                rstb = 1'b1;
            end else if (r <= 3) begin
                lamps = 3'(ill_codes[$urandom_range(0, 4)]);
                dur = $urandom_range(1, 5);
                for (int c = 0; c < dur; c++) begin
                    err_clr = ($urandom_range(0, 7) == 0);
                    @(negedge clk);
                end
            end else begin
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 2))
                        0: nxt = G;
                        1: nxt = A;
                        default: nxt = R;
                    endcase
                end
                lamps = nxt;
                dur = ($urandom_range(0, 14) == 0) ? 70 : $urandom_range(1, 12);
                for (int c = 0; c < dur; c++) begin
                    err_clr = ($urandom_range(0, 7) == 0);
                    @(negedge clk);
                end
                nxt = (nxt == G) ? A : (nxt == A) ? R : G;
            end
        end
        err_clr = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
